// File: rtl/core_pkg.sv
// Shared core encodings: writeback select, load types, register zero, WB register layout.
// Reused by decode, MEM and the MEM/WB stage.
package core_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd_addr;
        logic [1:0]  wb_sel;
        logic [2:0]  load_type;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] pc_plus4;
    } wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bundle: stage controls, MEM-side fields, and the register-file write port.
interface mem_wb_stage_if;

    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc_plus4;

    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic [31:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus4,
        input  wb_reg_write, wb_rd_addr, wb_rd_data, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel,
               mem_load_type, mem_alu_result, mem_load_data, mem_pc_plus4,
        output wb_reg_write, wb_rd_addr, wb_rd_data, instret
    );

endinterface

// File: rtl/mem_wb_stage_load_ext.sv
// load_ext: little-endian byte/halfword extraction with sign or zero extension.
// Purely combinational; instantiated only when WB_LOAD_EXT_EN is defined.
module load_ext
    import core_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data[7:0];
        case (offset)
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            2'd3:    byte_v = data[31:24];
            default: byte_v = data[7:0];
        endcase
        // offset[0] is ignored for halfwords: no misalignment trap
        half_v = offset[1] ? data[31:16] : data[15:0];

        case (load_type)
            LD_LB:   ext = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  ext = {24'd0, byte_v};
            LD_LH:   ext = {{16{half_v[15]}}, half_v};
            LD_LHU:  ext = {16'd0, half_v};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select and retired-instruction counter.
// Optional macro WB_LOAD_EXT_EN enables byte/halfword load extraction (load_ext).
module mem_wb_stage
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);

    wb_reg_t     r;
    logic [31:0] instret_q;
    logic [31:0] load_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (bus.flush) begin
            r.valid     <= 1'b0;
            r.reg_write <= 1'b0;
        end else if (!bus.stall) begin
            r <= '{valid:      bus.mem_valid,
                   reg_write:  bus.mem_reg_write,
                   rd_addr:    bus.mem_rd_addr,
                   wb_sel:     bus.mem_wb_sel,
                   load_type:  bus.mem_load_type,
                   alu_result: bus.mem_alu_result,
                   load_data:  bus.mem_load_data,
                   pc_plus4:   bus.mem_pc_plus4};
        end
    end

    // The WB instruction retires whenever the register is overwritten: normal
    // advance, or a flush replacing a stalled instruction with a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (r.valid && (!bus.stall || bus.flush)) begin
            instret_q <= instret_q + 32'd1;
        end
    end

`ifdef WB_LOAD_EXT_EN
    load_ext u_load_ext (
        .load_type (r.load_type),
        .offset    (r.alu_result[1:0]),
        .data      (r.load_data),
        .ext       (load_word)
    );
`else
    logic unused_load_type;
    assign unused_load_type = ^r.load_type;
    assign load_word        = r.load_data;
`endif

    always_comb begin
        case (r.wb_sel)
            WB_SEL_LOAD: bus.wb_rd_data = load_word;
            WB_SEL_LINK: bus.wb_rd_data = r.pc_plus4;
            default:     bus.wb_rd_data = r.alu_result;
        endcase
    end

    assign bus.wb_reg_write = r.valid & r.reg_write & (r.rd_addr != REG_ZERO);
    assign bus.wb_rd_addr   = r.rd_addr;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: random and directed stimulus against a behavioural model.
// Model honours WB_LOAD_EXT_EN the same way the build does.
module tb_mem_wb_stage;

    typedef struct {
        bit        valid;
        bit        rw;
        bit [4:0]  rd;
        bit [1:0]  sel;
        bit [2:0]  lt;
        bit [31:0] alu;
        bit [31:0] ld;
        bit [31:0] pc;
    } txn_t;

    typedef struct {
        bit        rw;
        bit [4:0]  rd;
        bit [31:0] data;
        bit [31:0] cnt;
        bit        chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus();
    mem_wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    txn_t      held;
    bit [31:0] cnt;
    bit        dknown;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the register file should receive for an instruction.
    function automatic bit [31:0] load_value(bit [2:0] lt, bit [31:0] ld, bit [1:0] off);
`ifdef WB_LOAD_EXT_EN
        bit [31:0] b, h;
        b = (ld >> (8 * off)) & 32'hFF;
        h = (ld >> (16 * off[1])) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return ld;
        endcase
`else
        return ld;
`endif
    endfunction

    function automatic bit [31:0] wb_value(txn_t t);
        if (t.sel == 2'd2) return t.pc;
        if (t.sel == 2'd1) return load_value(t.lt, t.ld, t.alu[1:0]);
        return t.alu;
    endfunction

    function automatic txn_t mk(bit v, bit rw, bit [4:0] rd, bit [1:0] sel, bit [2:0] lt,
                                bit [31:0] alu, bit [31:0] ld, bit [31:0] pc);
        txn_t t;
        t.valid = v; t.rw = rw; t.rd = rd; t.sel = sel; t.lt = lt;
        t.alu = alu; t.ld = ld; t.pc = pc;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
    endfunction

    function automatic void model_reset();
        held = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        dknown = 1;
    endfunction

    // Drives one cycle (called at posedge+3), pushes the expected post-edge outputs,
    // returns at posedge+3 after the monitor has consumed the entry.
    task automatic step(input txn_t t, input bit st, input bit fl);
        exp_t e;
        bus.mem_valid      = t.valid;
        bus.mem_reg_write  = t.rw;
        bus.mem_rd_addr    = t.rd;
        bus.mem_wb_sel     = t.sel;
        bus.mem_load_type  = t.lt;
        bus.mem_alu_result = t.alu;
        bus.mem_load_data  = t.ld;
        bus.mem_pc_plus4   = t.pc;
        bus.stall          = st;
        bus.flush          = fl;

        if (held.valid && (!st || fl)) cnt = cnt + 1;
        if (fl) begin
            held.valid = 0;
            held.rw    = 0;
            dknown     = 0;
        end else if (!st) begin
            held   = t;
            dknown = 1;
        end
        e.rw       = held.valid && held.rw && (held.rd != 0);
        e.rd       = held.rd;
        e.data     = wb_value(held);
        e.cnt      = cnt;
        e.chk_data = dknown;
        q.push_back(e);

        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_wb_reg_write", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("async_rst_wb_rd_addr", {27'd0, bus.wb_rd_addr}, 32'd0);
        chk("async_rst_wb_rd_data", bus.wb_rd_data, 32'd0);
        chk("async_rst_instret", bus.instret, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wb_reg_write", {31'd0, bus.wb_reg_write}, {31'd0, e.rw});
                chk("instret", bus.instret, e.cnt);
                if (e.chk_data) begin
                    chk("wb_rd_addr", {27'd0, bus.wb_rd_addr}, {27'd0, e.rd});
                    chk("wb_rd_data", bus.wb_rd_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    localparam bit [31:0] LDW = 32'h80F1_7F82;

    initial begin
        int guard;
        model_reset();
        step_idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_wb_reg_write", {31'd0, bus.wb_reg_write}, 32'd0);
        chk("rst_wb_rd_addr", {27'd0, bus.wb_rd_addr}, 32'd0);
        chk("rst_wb_rd_data", bus.wb_rd_data, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        rst_n = 1'b1;

        // ALU path, $0 suppression, reserved select
        step(mk(1, 1, 5, 0, 0, 32'h1234_5678, 0, 0), 0, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        step(mk(1, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0), 0, 0);
        step(mk(1, 1, 9, 3, 0, 32'hCAFE_0001, 32'h1, 32'h2), 0, 0);

        // Loads on 0x80F17F82
        step(mk(1, 1, 2, 1, 3'd1, 32'h0000_0100, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd2, 32'h0000_0100, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd1, 32'h0000_0101, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd3, 32'h0000_0102, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd4, 32'h0000_0102, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd3, 32'h0000_0103, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd0, 32'h0000_0103, LDW, 0), 0, 0);
        step(mk(1, 1, 2, 1, 3'd7, 32'h0000_0101, LDW, 0), 0, 0);

        // Link
        step(mk(1, 1, 31, 2, 0, 32'h5, 0, 32'h0040_0010), 0, 0);

        // Stall three cycles with fresh inputs, then stall+flush together
        step(mk(1, 1, 7, 0, 0, 32'hA5A5_0007, 0, 0), 0, 0);
        for (int i = 0; i < 3; i++) step(rnd_txn(), 1, 0);
        step(rnd_txn(), 1, 1);
        step(mk(1, 1, 8, 0, 0, 32'h0000_0008, 0, 0), 0, 0);
        step(mk(1, 1, 8, 0, 0, 32'h0000_0009, 0, 1), 0, 1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

        // Reset while a stalled instruction is held
        step(mk(1, 1, 12, 0, 0, 32'h1111_2222, 0, 0), 0, 0);
        step(rnd_txn(), 1, 0);
        do_reset();
        step(rnd_txn(), 1, 0);
        step(mk(1, 1, 13, 0, 0, 32'h3333_4444, 0, 0), 0, 0);

        // Counter wrap via preload
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cnt = 32'hFFFF_FFFF;
        step(mk(1, 1, 14, 0, 0, 32'h0, 0, 0), 0, 0);
        step(mk(1, 1, 15, 0, 0, 32'h1, 0, 0), 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(rnd_txn(), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic step_idle_inputs();
        bus.mem_valid      = 1'b0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_rd_addr    = '0;
        bus.mem_wb_sel     = '0;
        bus.mem_load_type  = '0;
        bus.mem_alu_result = '0;
        bus.mem_load_data  = '0;
        bus.mem_pc_plus4   = '0;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
    endtask

endmodule
